// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: encodings, ALU operations,
// FSM states, datapath select codes and the ALU/funct helper functions.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXECUTE, S_ALU_WB, S_ADDI_EXEC, S_ADDI_WB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  typedef enum logic [1:0] {
    PC_SEL_INC, PC_SEL_ALUOUT, PC_SEL_JUMP
  } pc_sel_t;

  typedef enum logic [1:0] {
    SRCB_B, SRCB_IMM, SRCB_IMM_SH2
  } srcb_sel_t;

  function automatic logic funct_legal(input logic [5:0] funct);
    logic ok;
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
      default:                               ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
    alu_op_t op;
    case (funct)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] alu_eval(input alu_op_t op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = {31'd0, ($signed(a) < $signed(b))};
      default: r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_mc_controller.sv
// Multicycle controller: per-instruction state sequencing, decode, and the
// enables/selects that steer the datapath and the unified memory port.
module mips_mc_controller
  import mips_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic      mem_ready,
  input  logic      a_eq_b,
  output logic      ir_we,
  output logic      pc_we,
  output pc_sel_t   pc_sel,
  output logic      ab_we,
  output logic      aluout_we,
  output logic      srca_pc,
  output srcb_sel_t srcb_sel,
  output alu_op_t   alu_op,
  output logic      mdr_we,
  output logic      rf_we,
  output logic      rf_dst_rd,
  output logic      rf_src_mdr,
  output logic      addr_aluout,
  output logic      mem_req,
  output logic      mem_we,
  output logic      retire,
  output logic      halted
);

  state_t state_q, state_d;
  logic   req_s, we_s, retire_s, halt_s;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d     = state_q;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = PC_SEL_INC;
    ab_we       = 1'b0;
    aluout_we   = 1'b0;
    srca_pc     = 1'b0;
    srcb_sel    = SRCB_B;
    alu_op      = ALU_ADD;
    mdr_we      = 1'b0;
    rf_we       = 1'b0;
    rf_dst_rd   = 1'b0;
    rf_src_mdr  = 1'b0;
    addr_aluout = 1'b0;
    req_s       = 1'b0;
    we_s        = 1'b0;
    retire_s    = 1'b0;
    halt_s      = 1'b0;
    case (state_q)
      S_FETCH: begin
        req_s = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target is formed speculatively from the already-incremented PC.
        ab_we     = 1'b1;
        aluout_we = 1'b1;
        srca_pc   = 1'b1;
        srcb_sel  = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE: begin
            if (funct_legal(funct)) begin
              state_d = S_EXECUTE;
            end else begin
              state_d = S_HALT;
            end
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDI_EXEC;
          OP_J:    state_d = S_JUMP;
          default: state_d = S_HALT;
        endcase
      end
      S_MEM_ADDR: begin
        aluout_we = 1'b1;
        srcb_sel  = SRCB_IMM;
        if (opcode == OP_SW) begin
          state_d = S_MEM_WRITE;
        end else begin
          state_d = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        req_s       = 1'b1;
        addr_aluout = 1'b1;
        if (mem_ready) begin
          mdr_we  = 1'b1;
          state_d = S_MEM_WB;
        end else begin
          state_d = S_MEM_READ;
        end
      end
      S_MEM_WB: begin
        rf_we      = 1'b1;
        rf_src_mdr = 1'b1;
        retire_s   = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        req_s       = 1'b1;
        we_s        = 1'b1;
        addr_aluout = 1'b1;
        if (mem_ready) begin
          retire_s = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_MEM_WRITE;
        end
      end
      S_EXECUTE: begin
        aluout_we = 1'b1;
        alu_op    = funct_to_alu(funct);
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        rf_we     = 1'b1;
        rf_dst_rd = 1'b1;
        retire_s  = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDI_EXEC: begin
        aluout_we = 1'b1;
        srcb_sel  = SRCB_IMM;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        rf_we    = 1'b1;
        retire_s = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        if (a_eq_b) begin
          pc_we  = 1'b1;
          pc_sel = PC_SEL_ALUOUT;
        end else begin
          pc_we  = 1'b0;
        end
        retire_s = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pc_we    = 1'b1;
        pc_sel   = PC_SEL_JUMP;
        retire_s = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        halt_s  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset abandons the current instruction, so no strobe may escape meanwhile.
  assign mem_req = req_s & ~reset;
  assign mem_we  = we_s & ~reset;
  assign retire  = retire_s & ~reset;
  assign halted  = halt_s & ~reset;

endmodule

// File: rtl/mips_multicycle.sv
// Multicycle MIPS-32 processor top: datapath registers, register file and ALU,
// sequenced by mips_mc_controller over a single request/ready memory port.
module mips_multicycle
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          REG_COUNT = 32
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        retire,
  output logic        halted,
  output logic [31:0] pc
);

  localparam int         IDX_W     = $clog2(REG_COUNT);
  localparam logic [5:0] REG_LIMIT = 6'(REG_COUNT);

  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0] aluout_q, aluout_d, mdr_q, mdr_d;
  logic [31:0] rf_q [REG_COUNT];
  logic [31:0] rf_d [REG_COUNT];

  logic        ir_we_s, pc_we_s, ab_we_s, aluout_we_s, srca_pc_s, mdr_we_s;
  logic        rf_we_s, rf_dst_rd_s, rf_src_mdr_s, addr_aluout_s;
  pc_sel_t     pc_sel_s;
  srcb_sel_t   srcb_sel_s;
  alu_op_t     alu_op_s;

  logic [4:0]  rs_s, rt_s, rd_s, wa_s;
  logic [31:0] imm_s, rs_val_s, rt_val_s, srca_s, srcb_s, alu_res_s, wdata_s;

  assign rs_s  = ir_q[25:21];
  assign rt_s  = ir_q[20:16];
  assign rd_s  = ir_q[15:11];
  assign imm_s = {{16{ir_q[15]}}, ir_q[15:0]};

  mips_mc_controller u_ctrl (
    .clock       (clock),
    .reset       (reset),
    .opcode      (ir_q[31:26]),
    .funct       (ir_q[5:0]),
    .mem_ready   (mem_ready),
    .a_eq_b      (a_q == b_q),
    .ir_we       (ir_we_s),
    .pc_we       (pc_we_s),
    .pc_sel      (pc_sel_s),
    .ab_we       (ab_we_s),
    .aluout_we   (aluout_we_s),
    .srca_pc     (srca_pc_s),
    .srcb_sel    (srcb_sel_s),
    .alu_op      (alu_op_s),
    .mdr_we      (mdr_we_s),
    .rf_we       (rf_we_s),
    .rf_dst_rd   (rf_dst_rd_s),
    .rf_src_mdr  (rf_src_mdr_s),
    .addr_aluout (addr_aluout_s),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .retire      (retire),
    .halted      (halted)
  );

  // Register-file reads; indices beyond the implemented file read as zero
  always_comb begin
    rs_val_s = 32'd0;
    rt_val_s = 32'd0;
    if ({1'b0, rs_s} < REG_LIMIT) begin
      rs_val_s = rf_q[rs_s[IDX_W-1:0]];
    end else begin
      rs_val_s = 32'd0;
    end
    if ({1'b0, rt_s} < REG_LIMIT) begin
      rt_val_s = rf_q[rt_s[IDX_W-1:0]];
    end else begin
      rt_val_s = 32'd0;
    end
  end

  // ALU operand selection and evaluation
  always_comb begin
    srca_s = srca_pc_s ? pc_q : a_q;
    case (srcb_sel_s)
      SRCB_B:       srcb_s = b_q;
      SRCB_IMM:     srcb_s = imm_s;
      SRCB_IMM_SH2: srcb_s = {imm_s[29:0], 2'b00};
      default:      srcb_s = b_q;
    endcase
    alu_res_s = alu_eval(alu_op_s, srca_s, srcb_s);
  end

  // Next values of the datapath holding registers
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    mdr_d    = mdr_q;
    if (pc_we_s) begin
      case (pc_sel_s)
        PC_SEL_INC:    pc_d = pc_q + 32'd4;
        PC_SEL_ALUOUT: pc_d = aluout_q;
        PC_SEL_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
        default:       pc_d = pc_q;
      endcase
    end else begin
      pc_d = pc_q;
    end
    if (ir_we_s) begin
      ir_d = mem_rdata;
    end else begin
      ir_d = ir_q;
    end
    if (ab_we_s) begin
      a_d = rs_val_s;
      b_d = rt_val_s;
    end else begin
      a_d = a_q;
      b_d = b_q;
    end
    if (aluout_we_s) begin
      aluout_d = alu_res_s;
    end else begin
      aluout_d = aluout_q;
    end
    if (mdr_we_s) begin
      mdr_d = mem_rdata;
    end else begin
      mdr_d = mdr_q;
    end
  end

  // Register-file write port; $0 and out-of-range indices discard writes
  always_comb begin
    rf_d    = rf_q;
    wa_s    = rf_dst_rd_s ? rd_s : rt_s;
    wdata_s = rf_src_mdr_s ? mdr_q : aluout_q;
    if (rf_we_s && (wa_s != 5'd0) && ({1'b0, wa_s} < REG_LIMIT)) begin
      rf_d[wa_s[IDX_W-1:0]] = wdata_s;
    end else begin
      rf_d = rf_q;
    end
  end

  // Datapath and register-file state
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= 32'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      aluout_q <= 32'd0;
      mdr_q    <= 32'd0;
      for (int i = 0; i < REG_COUNT; i++) begin
        rf_q[i] <= 32'd0;
      end
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
      rf_q     <= rf_d;
    end
  end

  assign mem_addr  = addr_aluout_s ? aluout_q : pc_q;
  assign mem_wdata = b_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: small programs in a behavioural memory,
// checked through stores, pc, retire/halt strobes and instruction latencies.
module tb_mips_multicycle;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

  logic [31:0] mem [0:255];
  int          n_vec = 0, n_bad = 0;
  int          wr_count = 0;
  logic [31:0] wr_addr = 32'd0;
  int          retires = 0, cycles = 0;
  bit          rand_ready = 1'b0;
  logic        stall_prev = 1'b0, stall_we = 1'b0;
  logic [31:0] stall_addr = 32'd0;

  always #5 clock = ~clock;

  mips_multicycle dut (
    .clock     (clock),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .retire    (retire),
    .halted    (halted),
    .pc        (pc)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clock) begin
    if (mem_req && mem_we && mem_ready) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      wr_count <= wr_count + 1;
      wr_addr  <= mem_addr;
    end
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: optional random ready, negedge sampling, stall-stability check.
  task automatic tick();
    if (rand_ready) mem_ready = 1'($urandom_range(0, 1));
    @(negedge clock);
    if (stall_prev) begin
      check_vec("stall_addr", mem_addr, stall_addr);
      check_vec("stall_we", {31'd0, mem_we}, {31'd0, stall_we});
    end
    stall_prev = mem_req && !mem_ready;
    stall_addr = mem_addr;
    stall_we   = mem_we;
    if (retire) retires++;
    @(posedge clock);
    #1;
    cycles++;
  endtask

  task automatic run_retires(input int n, input int budget, input string tag);
    int target;
    int lim;
    target = retires + n;
    lim    = 0;
    while (retires < target && lim < budget) begin
      tick();
      lim++;
    end
    check_vec(tag, 32'(retires), 32'(target));
  endtask

  task automatic timed_instr(input int exp_cycles, input string tag);
    int c0;
    c0 = cycles;
    run_retires(1, 20, tag);
    check_vec({tag, "_cycles"}, 32'(cycles - c0), 32'(exp_cycles));
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b1;
    tick();
    tick();
    check_vec("reset_req", {31'd0, mem_req}, 32'd0);
    check_vec("reset_retire", {31'd0, retire}, 32'd0);
    check_vec("reset_halted", {31'd0, halted}, 32'd0);
    check_vec("reset_pc", pc, 32'h0000_0000);
    reset = 1'b0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_BEEF;
  endtask

  initial begin
    int r0;
    int w0;
    mem_ready = 1'b1;
    fill_mem();

    // Program A: zero-wait arithmetic, then store/load under random ready
    mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
    mem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    mem[3] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0008);
    mem[4] = enc_i(6'h23, 5'd0, 5'd4, 16'h0008);
    mem[5] = enc_i(6'h2B, 5'd0, 5'd4, 16'h0080);
    do_reset();
    r0 = retires;
    for (int i = 0; i < 12; i++) tick();
    check_vec("progA_retires12", 32'(retires - r0), 32'd3);
    check_vec("progA_pc", pc, 32'h0000_000C);
    w0 = wr_count;
    rand_ready = 1'b1;
    run_retires(2, 200, "sw_lw_done");
    check_vec("sw_count", 32'(wr_count - w0), 32'd1);
    check_vec("sw_addr", wr_addr, 32'h0000_0008);
    check_vec("sw_data", mem[2], 32'd12);
    run_retires(1, 200, "sw4_done");
    check_vec("lw_after_sw", mem[32], 32'd12);
    rand_ready = 1'b0;
    mem_ready  = 1'b1;

    // Program B: branches, jump, ALU ops, $0, lw latency, illegal opcode
    reset = 1'b1;
    fill_mem();
    mem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
    mem[2]  = enc_i(6'h08, 5'd0, 5'd3, 16'd1);
    mem[3]  = enc_i(6'h08, 5'd0, 5'd4, 16'd2);
    mem[4]  = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
    mem[7]  = enc_i(6'h04, 5'd1, 5'd2, 16'd2);
    mem[8]  = {6'h02, 26'h000_0040};
    mem[64] = enc_i(6'h08, 5'd0, 5'd6, 16'hFFFF);
    mem[65] = enc_i(6'h08, 5'd0, 5'd7, 16'd1);
    mem[66] = enc_r(5'd6, 5'd7, 5'd5, 6'h2A);
    mem[67] = enc_r(5'd7, 5'd6, 5'd8, 6'h2A);
    mem[68] = enc_r(5'd1, 5'd2, 5'd9, 6'h22);
    mem[69] = enc_r(5'd1, 5'd2, 5'd10, 6'h24);
    mem[70] = enc_r(5'd1, 5'd2, 5'd11, 6'h25);
    mem[71] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
    mem[72] = enc_i(6'h2B, 5'd0, 5'd5, 16'h0084);
    mem[73] = enc_i(6'h2B, 5'd0, 5'd8, 16'h0088);
    mem[74] = enc_i(6'h2B, 5'd0, 5'd9, 16'h008C);
    mem[75] = enc_i(6'h2B, 5'd0, 5'd10, 16'h0090);
    mem[76] = enc_i(6'h2B, 5'd0, 5'd11, 16'h0094);
    mem[77] = enc_i(6'h2B, 5'd0, 5'd0, 16'h0098);
    mem[78] = enc_i(6'h23, 5'd0, 5'd12, 16'h0094);
    mem[79] = enc_i(6'h2B, 5'd0, 5'd12, 16'h009C);
    mem[80] = 32'hFC00_0000;
    do_reset();
    run_retires(4, 40, "progB_setup");
    timed_instr(3, "beq_taken");
    check_vec("beq_taken_pc", pc, 32'h0000_001C);
    timed_instr(3, "beq_not_taken");
    check_vec("beq_not_taken_pc", pc, 32'h0000_0020);
    timed_instr(3, "jump");
    check_vec("jump_pc", pc, 32'h0000_0100);
    timed_instr(4, "addi_lat");
    run_retires(13, 80, "alu_block");
    check_vec("slt_neg_lt_pos", mem[33], 32'd1);
    check_vec("slt_pos_lt_neg", mem[34], 32'd0);
    check_vec("sub", mem[35], 32'hFFFF_FFFE);
    check_vec("and", mem[36], 32'd5);
    check_vec("or", mem[37], 32'd7);
    check_vec("r0_write_ignored", mem[38], 32'd0);
    timed_instr(5, "lw_lat");
    timed_instr(4, "sw_lat");
    check_vec("lw_value", mem[39], 32'd7);
    r0 = retires;
    tick();
    tick();
    check_vec("halted_set", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_vec("halt_no_req", {31'd0, mem_req}, 32'd0);
    end
    check_vec("halt_no_retire", 32'(retires - r0), 32'd0);
    check_vec("halt_pc", pc, 32'h0000_0144);
    check_vec("halted_sticky", {31'd0, halted}, 32'd1);

    // Program C: reset during a stalled lw abandons it cleanly
    reset = 1'b1;
    fill_mem();
    mem[0] = enc_i(6'h23, 5'd0, 5'd4, 16'h0008);
    mem[2] = 32'h1234_5678;
    do_reset();
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    tick();
    check_vec("stalled_read_req", {31'd0, mem_req}, 32'd1);
    check_vec("stalled_read_addr", mem_addr, 32'h0000_0008);
    check_vec("stalled_read_we", {31'd0, mem_we}, 32'd0);
    r0 = retires;
    w0 = wr_count;
    do_reset();
    check_vec("abandon_no_retire", 32'(retires - r0), 32'd0);
    check_vec("abandon_no_write", 32'(wr_count - w0), 32'd0);
    @(negedge clock);
    check_vec("restart_req", {31'd0, mem_req}, 32'd1);
    check_vec("restart_addr", mem_addr, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
